// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// instr_loader: packs UART bytes (MSB first) into instruction words for imem.
// Optional INSTR_LOADER_CHECKSUM_EN adds an XOR checksum byte after the halt word.
// Revision: 1.0
// ============================================================================
module instr_loader #(
   parameter int               NBITS     = 32,
   parameter int               MAX_WORDS = 256,
   parameter logic [NBITS-1:0] HALT_WORD = 32'hFFFFFFFF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_byte_valid,
   input  logic [7:0]       i_byte,
   output logic [NBITS-1:0] o_instr_addr,
   output logic [NBITS-1:0] o_instr_data,
   output logic             o_instr_write,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_error,
   output logic [15:0]      o_word_count
);

   localparam int NBYTES = NBITS / 8;
   localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   // One extra bit so the index can reach MAX_WORDS for the overflow compare.
   localparam int WIDX_W = $clog2(MAX_WORDS + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RECV  = 3'd1,
      S_WRITE = 3'd2,
      S_DONE  = 3'd3
`ifdef INSTR_LOADER_CHECKSUM_EN
      ,S_CHKSUM = 3'd4
`endif
   } state_t;

   state_t             state_q, state_d;
   logic [NBITS-1:0]   shift_q, shift_d;
   logic [BIDX_W-1:0]  bidx_q, bidx_d;
   logic [WIDX_W-1:0]  widx_q, widx_d;
   logic [15:0]        cnt_q, cnt_d;
   logic               err_q, err_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [7:0]         xor_q, xor_d;
`endif

   logic [WIDX_W-1:0]  widx_inc;
   logic [NBITS-1:0]   shift_in;

   assign widx_inc = widx_q + WIDX_W'(1);
   assign shift_in = {shift_q[NBITS-9:0], i_byte};

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         bidx_q  <= '0;
         widx_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
         xor_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bidx_q  <= bidx_d;
         widx_q  <= widx_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
         xor_q   <= xor_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bidx_d  = bidx_q;
      widx_d  = widx_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
      xor_d   = xor_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            // A byte arriving together with i_start is dropped on purpose.
            if (i_start) begin
               state_d = S_RECV;
               shift_d = '0;
               bidx_d  = '0;
               widx_d  = '0;
               cnt_d   = '0;
               err_d   = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
               xor_d   = '0;
`endif
            end
         end
         S_RECV: begin
            if (i_byte_valid) begin
               shift_d = shift_in;
`ifdef INSTR_LOADER_CHECKSUM_EN
               xor_d   = xor_q ^ i_byte;
`endif
               if (bidx_q == BIDX_W'(NBYTES - 1)) begin
                  bidx_d  = '0;
                  state_d = S_WRITE;
               end else begin
                  bidx_d = bidx_q + BIDX_W'(1);
               end
            end
         end
         S_WRITE: begin
            widx_d = widx_inc;
            cnt_d  = cnt_q + 16'd1;
            bidx_d = '0;
            if (shift_q == HALT_WORD) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
               // A byte landing in this cycle is the checksum itself.
               if (i_byte_valid) begin
                  state_d = S_DONE;
                  err_d   = (i_byte != xor_q);
               end else begin
                  state_d = S_CHKSUM;
               end
`else
               state_d = S_DONE;
`endif
            end else if (widx_inc == WIDX_W'(MAX_WORDS)) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               state_d = S_RECV;
               // Byte overlapping the strobe becomes byte 0 of the next word.
               if (i_byte_valid) begin
                  shift_d = shift_in;
                  bidx_d  = BIDX_W'(1);
`ifdef INSTR_LOADER_CHECKSUM_EN
                  xor_d   = xor_q ^ i_byte;
`endif
               end
            end
         end
`ifdef INSTR_LOADER_CHECKSUM_EN
         S_CHKSUM: begin
            if (i_byte_valid) begin
               state_d = S_DONE;
               err_d   = (i_byte != xor_q);
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   assign o_instr_addr  = NBITS'({widx_q, 2'b00});
   assign o_instr_data  = shift_q;
   assign o_instr_write = (state_q == S_WRITE);
   assign o_busy        = (state_q == S_RECV) || (state_q == S_WRITE);
   assign o_done        = (state_q == S_DONE);
   assign o_error       = err_q;
   assign o_word_count  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// Bench for instr_loader: directed scenarios plus random loads against a
// word-list reference model (MAX_WORDS=4 so overflow is reachable).
module tb_instr_loader;

   localparam int          NBITS = 32;
   localparam int          MAXW  = 4;
   localparam logic [31:0] HALT  = 32'hFFFFFFFF;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              bvalid;
   logic [7:0]        bdata;
   logic [NBITS-1:0]  addr;
   logic [NBITS-1:0]  data;
   logic              wr;
   logic              busy;
   logic              done;
   logic              err;
   logic [15:0]       wcnt;

   int checks = 0;
   int errors = 0;

   logic [63:0] cap_q[$];
   logic [63:0] exp_q[$];
   logic [7:0]  tx_q[$];
   logic        exp_err;
   int          exp_cnt;

   always #10 clk = ~clk;

   instr_loader #(.NBITS(NBITS), .MAX_WORDS(MAXW), .HALT_WORD(HALT)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_byte_valid(bvalid),
      .i_byte      (bdata),
      .o_instr_addr(addr),
      .o_instr_data(data),
      .o_instr_write(wr),
      .o_busy      (busy),
      .o_done      (done),
      .o_error     (err),
      .o_word_count(wcnt)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Write-port monitor: records every strobe and checks its side conditions.
   always @(negedge clk) begin
      if (wr === 1'b1) begin
         cap_q.push_back({addr, data});
         check("wr_while_busy", {63'd0, busy}, 64'd1);
         check("wr_addr_range", {63'd0, (addr <= 32'((MAXW - 1) * 4))}, 64'd1);
      end
   end

   // Reference: chop the byte stream into big-endian words and stop at the
   // halt word or when memory is full.
   task automatic model();
      logic [31:0] w;
      exp_q.delete();
      exp_err = 1'b0;
      for (int k = 0; 4 * k + 3 < tx_q.size(); k++) begin
         w = {tx_q[4*k], tx_q[4*k+1], tx_q[4*k+2], tx_q[4*k+3]};
         exp_q.push_back({32'(k * 4), w});
         if (w == HALT) break;
         if (k + 1 == MAXW) begin
            exp_err = 1'b1;
            break;
         end
      end
      exp_cnt = exp_q.size();
   endtask

   task automatic do_start(input logic with_byte, input logic [7:0] b);
      start  = 1'b1;
      bvalid = with_byte;
      bdata  = b;
      tick();
      start  = 1'b0;
      bvalid = 1'b0;
   endtask

   task automatic begin_load(input logic with_byte, input logic [7:0] b);
      cap_q.delete();
      do_start(with_byte, b);
      check("busy_after_start", {63'd0, busy}, 64'd1);
   endtask

   task automatic send_all(input int maxgap);
      for (int i = 0; i < tx_q.size(); i++) begin
         bdata  = tx_q[i];
         bvalid = 1'b1;
         tick();
         bvalid = 1'b0;
         if ((i % 4 == 3) && (i / 4 < exp_q.size()))
            check("strobe_latency", {63'd0, wr}, 64'd1);
         repeat ($urandom_range(0, maxgap)) tick();
      end
   endtask

   task automatic finish_load(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check({tag, "_done"}, {63'd0, done}, 64'd1);
      check({tag, "_nwrites"}, 64'(cap_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
         check({tag, "_write"}, cap_q[i], exp_q[i]);
      check({tag, "_error"}, {63'd0, err}, {63'd0, exp_err});
      check({tag, "_count"}, {48'd0, wcnt}, 64'(exp_cnt));
      check({tag, "_busy"}, {63'd0, busy}, 64'd0);
   endtask

   initial begin
      int nw;
      int nhalt;
      logic [31:0] w;
      rst    = 1'b0;
      start  = 1'b0;
      bvalid = 1'b0;
      bdata  = 8'h00;
      repeat (3) tick();
      check("rst_busy",  {63'd0, busy}, 64'd0);
      check("rst_done",  {63'd0, done}, 64'd0);
      check("rst_error", {63'd0, err},  64'd0);
      check("rst_wr",    {63'd0, wr},   64'd0);
      check("rst_count", {48'd0, wcnt}, 64'd0);
      check("rst_addr",  {32'd0, addr}, 64'd0);
      check("rst_data",  {32'd0, data}, 64'd0);
      rst = 1'b1;
      tick();
      // Stray byte in IDLE must not start anything.
      bdata = 8'h5A; bvalid = 1'b1; tick(); bvalid = 1'b0;
      check("idle_byte_busy", {63'd0, busy}, 64'd0);

      // Basic load with halt word.
      tx_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      model();
      begin_load(1'b0, 8'h00);
      send_all(1);
      finish_load("basic");

      // Byte coinciding with start is dropped.
      tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      model();
      begin_load(1'b1, 8'hAA);
      send_all(0);
      finish_load("start_drop");

      // Overflow with 17 non-halt bytes; the extra byte must be ignored.
      tx_q.delete();
      for (int i = 0; i < 17; i++)
         tx_q.push_back((i % 4 == 0) ? 8'($urandom_range(0, 254)) : 8'($urandom));
      model();
      begin_load(1'b0, 8'h00);
      send_all(0);
      finish_load("overflow");
      bdata = 8'h77; bvalid = 1'b1; tick(); bvalid = 1'b0; tick();
      check("done_byte_nowrite", 64'(cap_q.size()), 64'(exp_q.size()));
      check("done_hold", {63'd0, done}, 64'd1);
      check("done_hold_count", {48'd0, wcnt}, 64'(exp_cnt));

      // Byte in the strobe cycle, plus a start pulse mid-load that is ignored.
      tx_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h11, 8'h22, 8'h33, 8'h44,
               8'hFF, 8'hFF, 8'hFF, 8'hFF};
      model();
      begin_load(1'b0, 8'h00);
      for (int i = 0; i < tx_q.size(); i++) begin
         bdata = tx_q[i]; bvalid = 1'b1; tick(); bvalid = 1'b0;
         if (i == 9) do_start(1'b0, 8'h00);
      end
      finish_load("write_cycle_byte");

      // Reset in the middle of a word.
      cap_q.delete();
      do_start(1'b0, 8'h00);
      bdata = 8'h99; bvalid = 1'b1; tick(); tick(); bvalid = 1'b0;
      rst = 1'b0; tick();
      check("midrst_busy",  {63'd0, busy}, 64'd0);
      check("midrst_count", {48'd0, wcnt}, 64'd0);
      rst = 1'b1; tick();
      tx_q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      model();
      begin_load(1'b0, 8'h00);
      send_all(2);
      finish_load("mid_reset");

      // Random loads with random gaps.
      for (int it = 0; it < 20; it++) begin
         nw = $urandom_range(1, 5);
         nhalt = 0;
         tx_q.delete();
         for (int k = 0; k < nw; k++) begin
            w = ($urandom_range(0, 3) == 0) ? HALT : 32'($urandom);
            if (k == nw - 1 && nw < MAXW && nhalt == 0) w = HALT;
            if (w == HALT) nhalt++;
            for (int b = 3; b >= 0; b--) tx_q.push_back(w[8*b +: 8]);
         end
         model();
         begin_load(($urandom_range(0, 1) == 1), 8'($urandom));
         send_all($urandom_range(0, 2));
         finish_load("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Sits between the UART RX path and the instruction-fetch instruction-memory write port, under Debug_Unit control.
- Assembles received bytes into 32-bit instruction words (MSB first) and writes them to consecutive word addresses starting at 0.
- Stops on a halt-marker word or on memory overflow, then reports completion and the word count back to Debug_Unit.

Parameters:
- NBITS, 32, instruction word and address width.
- MAX_WORDS, 256, instruction memory capacity in words.
- HALT_WORD, 32'hFFFFFFFF, terminator word. It is written to memory, then loading ends.

Ports:
- i_clk  in  1  system clock (50 MHz domain).
- i_rst  in  1  synchronous, active-low reset.
- i_start  in  1  one-cycle pulse from Debug_Unit; begins a load.
- i_byte_valid  in  1  one-cycle pulse; UART byte received.
- i_byte  in  8  received UART byte.
- o_instr_addr  out  NBITS  byte address to instruction memory (word index × 4).
- o_instr_data  out  NBITS  assembled instruction word.
- o_instr_write  out  1  one-cycle write strobe to instruction memory.
- o_busy  out  1  high in RECV and WRITE.
- o_done  out  1  high in DONE until the next i_start or reset.
- o_error  out  1  overflow (or checksum failure, see the optional feature); valid while o_done.
- o_word_count  out  16  number of words written, halt word included.

Behaviour:
- Reset (i_rst==0 at a clock edge): state IDLE; all outputs 0; byte index 0; word index 0; shift register 0.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - i_start → RECV; clear the word index, byte index, word count and error.
  - i_byte_valid without i_start is ignored.
  - i_start and i_byte_valid in the same cycle: start is taken, the byte is dropped.
- RECV:
  - On each i_byte_valid: shift register = {shift[23:0], i_byte}; byte index +1.
  - When the 4th byte arrives, go to WRITE next cycle with o_instr_data = the assembled word.
  - i_start in RECV is ignored; there is no restart mid-load.
- WRITE (exactly 1 cycle):
  - o_instr_write=1, o_instr_addr = word index<<2; o_instr_data and o_instr_addr are stable in this cycle.
  - On exit: word index +1, o_word_count +1, byte index cleared.
  - If the word == HALT_WORD → DONE.
  - Else if the incremented word index == MAX_WORDS → DONE with o_error=1.
  - Else → RECV.
  - An i_byte_valid arriving in the WRITE cycle is accepted as byte 0 of the next word; no byte is lost.
- Latency: write strobe 1 cycle after the 4th byte's valid pulse.
- DONE:
  - Hold o_done, o_error and o_word_count.
  - i_byte_valid is ignored.
  - i_start → RECV with a fresh clear (same as from IDLE).
- o_instr_write is never high outside WRITE.
- Address never exceeds (MAX_WORDS-1)*4.
- Reset mid-load aborts immediately to IDLE. Words already written stay in memory; the loader does not clear memory.
- o_word_count saturates naturally: MAX_WORDS ≤ 65535 is required.

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN.
- When defined:
  - An 8-bit running XOR of every accepted byte is kept, including the halt word's bytes.
  - After the halt-word WRITE, the FSM enters an extra state CHKSUM and waits for one more byte.
  - If the byte equals the running XOR → DONE, o_error=0; otherwise → DONE, o_error=1.
  - The overflow path skips CHKSUM.
  - Reset and i_start clear the XOR.
- When undefined: CHKSUM state and XOR register are absent; the halt word goes directly to DONE; o_error means overflow only.

Test Plan:
- Reset, pulse i_start, send bytes 20 08 00 05 then FF FF FF FF → write (addr 0x0, data 0x20080005), then write (addr 0x4, data 0xFFFFFFFF); o_done=1, o_error=0, o_word_count=2.
- i_start and i_byte_valid (0xAA) in the same cycle, then bytes 01 02 03 04 → first write data is 0x01020304, not 0xAA010203.
- MAX_WORDS=4, send 16 non-halt bytes → 4 writes at addresses 0x0, 0x4, 0x8, 0xC; o_done=1, o_error=1; a 17th byte causes no write.
- Byte valid in the WRITE cycle: send 4 bytes, then byte 0x11 exactly in the strobe cycle, then 22 33 44 → next write data 0x11223344 at addr 0x4.
- Send 2 bytes, drive i_rst=0 for one cycle, then i_start and 00 00 00 01 FF FF FF FF → first write data 0x00000001 at addr 0x0; o_word_count=2.
- With INSTR_LOADER_CHECKSUM_EN: send 01 02 03 04 FF FF FF FF, then checksum 0x04 → o_error=0. Repeat with checksum 0x05 → o_error=1.
